// File: rtl/cv_tmdsenc_mc.sv
// Multi-lane TMDS (DVI 1.0) encoder.
// Each lane is a two-stage pipeline:
//   - stage 1 registers the transition-minimised word q_m[8:0] and the control pair;
//   - stage 2 applies DC balancing against a signed running disparity counter,
//     or emits a control token.
// The de input is common to all lanes, so its stage-1 copy is shared.
// Lanes keep independent disparity counters and sticky range-error flags.
// tst_ld_i/tst_cnt_i preload a lane counter so the clamp path can be exercised.
// cnt_o exposes every lane counter for observation.
// Handshake: no valid/ready pair here. din_en=1 advances every register by one
// stage; din_en=0 freezes the whole pipeline, outputs included.
module cv_tmdsenc_mc #(
   parameter int NCH = 3,
   parameter int CW  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   input  logic              din_en,
   input  logic              de,
   input  logic [8*NCH-1:0]  din,
   input  logic [2*NCH-1:0]  ctl,
   input  logic [NCH-1:0]    tst_ld_i,
   input  logic [CW-1:0]     tst_cnt_i,
   output logic [10*NCH-1:0] dout,
   output logic              de_out,
   output logic [NCH-1:0]    disp_err,
   output logic [CW*NCH-1:0] cnt_o
);

   // Disparity arithmetic is done two bits wider than the counter.
   // This lets an out-of-range result be seen before it is clamped.
   localparam int XW = CW + 2;
   localparam logic signed [XW-1:0] CNT_MAX = XW'(16);
   localparam logic signed [XW-1:0] CNT_MIN = XW'(-16);
   localparam logic signed [XW-1:0] TWO     = XW'(2);
   localparam logic signed [XW-1:0] ZERO    = '0;

   // Population count of a byte.
   function automatic logic [3:0] ones8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   // Transition-minimised word.
   // XNOR chaining is used for heavy bytes and for four-ones bytes with d[0]=0.
   // q_m[8] records which chaining was used (1 = XOR).
   function automatic logic [8:0] qm_f(input logic [7:0] d);
      logic [3:0] n1;
      logic       use_xnor;
      logic [8:0] q;
      n1       = ones8(d);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      q        = '0;
      q[0]     = d[0];
      for (int i = 1; i < 8; i++) begin
         q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      end
      q[8] = ~use_xnor;
      return q;
   endfunction

   // Control-period token for {C1,C0}.
   function automatic logic [9:0] ctl_tok(input logic [1:0] c);
      logic [9:0] t;
      case (c)
         2'b00:   t = 10'h354;
         2'b01:   t = 10'h0AB;
         2'b10:   t = 10'h154;
         default: t = 10'h2AB;
      endcase
      return t;
   endfunction

   // Shared stage-1 state.
   // v1_q marks that stage 1 holds a real sample since the last clear.
   // While it is low, stage 2 keeps emitting zeros instead of a bogus token.
   logic v1_q;
   logic de1_q;
   logic de_out_q;

   // Shared pipeline bookkeeping: valid flag, stage-1 de and the aligned de_out.
   always_ff @(posedge clk) begin
      if (reset || !cs) begin
         v1_q     <= 1'b0;
         de1_q    <= 1'b0;
         de_out_q <= 1'b0;
      end else if (din_en) begin
         v1_q     <= 1'b1;
         de1_q    <= de;
         de_out_q <= de1_q;
      end
   end

   assign de_out = de_out_q;

   for (genvar k = 0; k < NCH; k++) begin : g_lane
      logic [8:0]           qm_q;
      logic [1:0]           ctl_q;
      logic [9:0]           dout_q;
      logic [9:0]           dout_d;
      logic [CW-1:0]        cnt_q;
      logic [CW-1:0]        cnt_d;
      logic                 err_q;
      logic                 err_d;
      logic [3:0]           n1;
      logic [3:0]           n0;
      logic                 cnt_zero;
      logic                 cnt_pos;
      logic                 cnt_neg;
      logic signed [XW-1:0] cnt_x;
      logic signed [XW-1:0] diff;
      logic signed [XW-1:0] delta;
      logic signed [XW-1:0] sum;

      // Stage 2 next state.
      // Selects a control token or a DC-balanced data symbol, then clamps the
      // updated disparity and raises the sticky error on overflow.
      always_comb begin
         n1       = ones8(qm_q[7:0]);
         n0       = 4'd8 - n1;
         cnt_zero = (cnt_q == '0);
         cnt_neg  = cnt_q[CW-1];
         cnt_pos  = !cnt_neg && !cnt_zero;
         cnt_x    = {{2{cnt_q[CW-1]}}, cnt_q};
         diff     = $signed({{(XW-4){1'b0}}, n1}) - $signed({{(XW-4){1'b0}}, n0});
         delta    = ZERO;
         sum      = cnt_x;
         dout_d   = '0;
         cnt_d    = cnt_q;
         err_d    = err_q;
         if (!v1_q) begin
            dout_d = '0;
         end else if (!de1_q) begin
            dout_d = ctl_tok(ctl_q);
            cnt_d  = '0;
         end else begin
            if (cnt_zero || (n1 == n0)) begin
               dout_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
               delta  = qm_q[8] ? diff : (ZERO - diff);
            end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
               dout_d = {1'b1, qm_q[8], ~qm_q[7:0]};
               delta  = (qm_q[8] ? TWO : ZERO) - diff;
            end else begin
               dout_d = {1'b0, qm_q[8], qm_q[7:0]};
               delta  = diff - (qm_q[8] ? ZERO : TWO);
            end
            sum = cnt_x + delta;
            if (sum > CNT_MAX) begin
               cnt_d = CNT_MAX[CW-1:0];
               err_d = 1'b1;
            end else if (sum < CNT_MIN) begin
               cnt_d = CNT_MIN[CW-1:0];
               err_d = 1'b1;
            end else begin
               cnt_d = sum[CW-1:0];
            end
         end
      end

      // Lane registers.
      // A clear (reset or cs low) wins over everything.
      // Otherwise the lane advances only on din_en.
      // The counter preload is applied last so that it overrides the normal update.
      always_ff @(posedge clk) begin
         if (reset || !cs) begin
            qm_q   <= '0;
            ctl_q  <= '0;
            dout_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
         end else begin
            if (din_en) begin
               qm_q   <= qm_f(din[8*k +: 8]);
               ctl_q  <= ctl[2*k +: 2];
               dout_q <= dout_d;
               cnt_q  <= cnt_d;
               err_q  <= err_d;
            end
            if (tst_ld_i[k]) begin
               cnt_q <= tst_cnt_i;
            end
         end
      end

      assign dout[10*k +: 10] = dout_q;
      assign disp_err[k]      = err_q;
      assign cnt_o[CW*k +: CW] = cnt_q;
   end

endmodule

// File: tb/tb_cv_tmdsenc_mc.sv
// Directed bench for cv_tmdsenc_mc (3 lanes, 6-bit counters).
// Expected symbols and counter values below are worked out by hand from the
// DVI encoding rules.
module tb_cv_tmdsenc_mc;

  localparam int NCH = 3;
  localparam int CW  = 6;

  logic              clk;
  logic              reset;
  logic              cs;
  logic              din_en;
  logic              de;
  logic [8*NCH-1:0]  din;
  logic [2*NCH-1:0]  ctl;
  logic [NCH-1:0]    tst_ld_i;
  logic [CW-1:0]     tst_cnt_i;
  logic [10*NCH-1:0] dout;
  logic              de_out;
  logic [NCH-1:0]    disp_err;
  logic [CW*NCH-1:0] cnt_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  tbl [8];
  logic [9:0]  enc [8];
  logic [31:0] exp_v;

  cv_tmdsenc_mc #(.NCH(NCH), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .din_en    (din_en),
    .de        (de),
    .din       (din),
    .ctl       (ctl),
    .tst_ld_i  (tst_ld_i),
    .tst_cnt_i (tst_cnt_i),
    .dout      (dout),
    .de_out    (de_out),
    .disp_err  (disp_err),
    .cnt_o     (cnt_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // pack three lane symbols (lane2, lane1, lane0)
  function automatic logic [31:0] sym3(input logic [9:0] s2, input logic [9:0] s1,
                                       input logic [9:0] s0);
    return {2'b00, s2, s1, s0};
  endfunction

  // pack three signed lane counters (lane2, lane1, lane0)
  function automatic logic [31:0] cnt3(input int c2, input int c1, input int c0);
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] c;
    a = c2[5:0];
    b = c1[5:0];
    c = c0[5:0];
    return {14'b0, a, b, c};
  endfunction

  function automatic logic [31:0] dout32();
    return {2'b00, dout};
  endfunction

  function automatic logic [31:0] cnt32();
    return {14'b0, cnt_o};
  endfunction

  initial begin
    // single symbols encoded from a zero counter
    tbl = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'hF0, 8'h01, 8'h80, 8'h1F};
    enc = '{10'h100, 10'h200, 10'h133, 10'h105, 10'h205, 10'h1FF, 10'h180, 10'h2A0};

    reset     = 1'b1;
    cs        = 1'b1;
    din_en    = 1'b1;
    de        = 1'b0;
    din       = '0;
    ctl       = '0;
    tst_ld_i  = '0;
    tst_cnt_i = '0;
    tick();
    tick();
    check("rst_dout", dout32(), 32'h0);
    check("rst_de_out", {31'b0, de_out}, 32'h0);
    check("rst_err", {29'b0, disp_err}, 32'h0);
    check("rst_cnt", cnt32(), 32'h0);

    // data burst: lane0 0x00, lane1 0x55, lane2 0xFF
    reset = 1'b0;
    de    = 1'b1;
    din   = {8'hFF, 8'h55, 8'h00};
    tick();
    check("lat_zero", dout32(), 32'h0);
    tick();
    check("d1_dout", dout32(), sym3(10'h200, 10'h133, 10'h100));
    check("d1_cnt", cnt32(), cnt3(-8, 0, -8));
    check("d1_de_out", {31'b0, de_out}, 32'h1);
    tick();
    check("d2_dout", dout32(), sym3(10'h0FF, 10'h133, 10'h3FF));
    check("d2_cnt", cnt32(), cnt3(-2, 0, 2));
    tick();
    check("d3_dout", dout32(), sym3(10'h0FF, 10'h133, 10'h100));
    check("d3_cnt", cnt32(), cnt3(4, 0, -6));

    // pipeline hold: garbage on the inputs must not leak through
    din_en = 1'b0;
    din    = 24'hAAAAAA;
    de     = 1'b0;
    tick();
    tick();
    check("hold_dout", dout32(), sym3(10'h0FF, 10'h133, 10'h100));
    check("hold_cnt", cnt32(), cnt3(4, 0, -6));
    check("hold_de_out", {31'b0, de_out}, 32'h1);
    din_en = 1'b1;
    de     = 1'b1;
    din    = {8'hFF, 8'h55, 8'h00};
    tick();
    check("resume_dout", dout32(), sym3(10'h200, 10'h133, 10'h3FF));
    check("resume_cnt", cnt32(), cnt3(-4, 0, 4));

    // de 1->0: the last data symbol still emerges, then tokens
    de  = 1'b0;
    ctl = {2'b10, 2'b01, 2'b00};
    tick();
    check("tail_dout", dout32(), sym3(10'h0FF, 10'h133, 10'h100));
    check("tail_cnt", cnt32(), cnt3(2, 0, -4));
    check("tail_de_out", {31'b0, de_out}, 32'h1);
    tick();
    check("ctl_a_dout", dout32(), sym3(10'h154, 10'h0AB, 10'h354));
    check("ctl_a_de_out", {31'b0, de_out}, 32'h0);
    check("ctl_a_cnt", cnt32(), 32'h0);
    ctl = {2'b00, 2'b10, 2'b11};
    tick();
    tick();
    check("ctl_b_dout", dout32(), sym3(10'h354, 10'h154, 10'h2AB));

    // de 0->1: first symbol is encoded from a zero counter
    de  = 1'b1;
    din = {8'hFF, 8'h55, 8'h00};
    tick();
    check("rise_hold_ctl", dout32(), sym3(10'h354, 10'h154, 10'h2AB));
    tick();
    check("rise_dout", dout32(), sym3(10'h200, 10'h133, 10'h100));
    check("rise_cnt", cnt32(), cnt3(-8, 0, -8));

    // one-cycle reset in the middle of a burst
    reset = 1'b1;
    tick();
    check("midrst_dout", dout32(), 32'h0);
    check("midrst_cnt", cnt32(), 32'h0);
    check("midrst_de_out", {31'b0, de_out}, 32'h0);
    reset = 1'b0;
    tick();
    check("postrst_zero", dout32(), 32'h0);
    tick();
    check("postrst_first", dout32(), sym3(10'h200, 10'h133, 10'h100));

    // alternate data and control so that every data symbol starts from cnt=0
    de  = 1'b0;
    ctl = '0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      de  = 1'b1;
      din = {tbl[(i+2)%8], tbl[(i+1)%8], tbl[i]};
      exp_q.push_back(sym3(enc[(i+2)%8], enc[(i+1)%8], enc[i]));
      tick();
      check("tbl_ctl", dout32(), sym3(10'h354, 10'h354, 10'h354));
      de = 1'b0;
      tick();
      exp_v = exp_q.pop_front();
      check("tbl_data", dout32(), exp_v);
    end

    // preload counters out of range, then let one balanced symbol clamp them
    de  = 1'b1;
    din = {8'h55, 8'h55, 8'h55};
    tick();
    tick();
    check("bal_dout", dout32(), sym3(10'h133, 10'h133, 10'h133));
    check("bal_cnt", cnt32(), 32'h0);
    din_en    = 1'b0;
    tst_ld_i  = 3'b001;
    tst_cnt_i = 6'd20;
    tick();
    tst_ld_i  = 3'b010;
    tst_cnt_i = 6'b101100;
    tick();
    tst_ld_i = '0;
    check("preload_no_err", {29'b0, disp_err}, 32'h0);
    din_en = 1'b1;
    tick();
    check("clamp_cnt", cnt32(), cnt3(0, -16, 16));
    check("clamp_err", {29'b0, disp_err}, 32'h3);
    check("clamp_dout", dout32(), sym3(10'h133, 10'h133, 10'h133));
    tick();
    check("sticky_err", {29'b0, disp_err}, 32'h3);
    check("sticky_cnt", cnt32(), cnt3(0, -16, 16));

    // block deselect clears everything, even with the pipeline frozen
    din_en = 1'b0;
    cs     = 1'b0;
    tick();
    check("cs_err", {29'b0, disp_err}, 32'h0);
    check("cs_cnt", cnt32(), 32'h0);
    check("cs_dout", dout32(), 32'h0);
    cs     = 1'b1;
    din_en = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
